// File: rtl/prm_edge_scan_seq.sv
// PRM edge-check scan initiator: sweeps a code range through the checker
// and packs the returned edge_mask bits LSB-first into output words.
module prm_edge_scan_seq #(
  parameter int CODE_W  = 15,
  parameter int WORD_W  = 32,
  parameter int CHK_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CODE_W-1:0]        code_lo,
  input  logic [CODE_W-1:0]        code_hi,
  output logic [CODE_W-1:0]        chk_code,
  input  logic                     chk_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic [CODE_W-1:0]        out_base,
  output logic [$clog2(WORD_W):0]  out_count,
  output logic                     busy,
  output logic                     done,
  output logic [CODE_W:0]          blocked_cnt
);

  localparam int AW = $clog2(WORD_W);
  localparam int CW = AW + 1;
  localparam int LP = (CHK_LAT > 0) ? CHK_LAT : 1;
  localparam int BW = CODE_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state;
  logic [CODE_W:0]   cur;
  logic [CODE_W:0]   hi_q;
  logic [LP-1:0]     vpipe;
  logic [WORD_W-1:0] acc_data;
  logic [WORD_W-1:0] nxt_data;
  logic [CW-1:0]     acc_cnt;
  logic [CW-1:0]     nxt_cnt;
  logic [CW-1:0]     inflight;
  logic [CODE_W-1:0] acc_base;
  logic              fire;
  logic              last;
  logic              res_v;
  logic              out_free;
  logic              move;

  assign chk_code = cur[CODE_W-1:0];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LP; i++) begin
      inflight = inflight + CW'(vpipe[i]);
    end
  end

  // Room is reserved for every result still in the checker pipe,
  // so a full accumulator never has to refuse an arriving mask.
  assign fire  = (state == S_ISSUE) &&
                 ((acc_cnt + inflight) < CW'(WORD_W));
  assign last  = (cur == hi_q);
  assign res_v = (CHK_LAT == 0) ? fire : vpipe[LP-1];

  always_comb begin
    nxt_data = acc_data;
    nxt_cnt  = acc_cnt;
    if (res_v) begin
      nxt_data[acc_cnt[AW-1:0]] = chk_mask;
      nxt_cnt = acc_cnt + CW'(1);
    end
  end

  assign out_free = !out_valid || out_ready;
  assign move = out_free &&
                ((nxt_cnt == CW'(WORD_W)) ||
                 ((state == S_FLUSH) && (acc_cnt != '0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur         <= '0;
      hi_q        <= '0;
      vpipe       <= '0;
      acc_data    <= '0;
      acc_cnt     <= '0;
      acc_base    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_base    <= '0;
      out_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      blocked_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (move) begin
        out_valid <= 1'b1;
        out_data  <= nxt_data;
        out_base  <= acc_base;
        out_count <= nxt_cnt;
        acc_data  <= '0;
        acc_cnt   <= '0;
        acc_base  <= acc_base + CODE_W'(nxt_cnt);
      end else begin
        acc_data <= nxt_data;
        acc_cnt  <= nxt_cnt;
      end
      if (res_v) begin
        blocked_cnt <= blocked_cnt + BW'(chk_mask);
      end
      for (int i = LP - 1; i > 0; i--) begin
        vpipe[i] <= vpipe[i-1];
      end
      vpipe[0] <= (CHK_LAT > 0) ? fire : 1'b0;
      if (fire && !last) begin
        cur <= cur + BW'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            blocked_cnt <= '0;
            acc_base    <= code_lo;
            cur         <= {1'b0, code_lo};
            hi_q        <= {1'b0, code_hi};
            if (code_lo <= code_hi) begin
              state <= S_ISSUE;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (fire && last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (vpipe == '0) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if ((acc_cnt == '0) && out_free) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_scan_seq.sv
// Bench for prm_edge_scan_seq: two instances (checker latency 0 and 2)
// run the same scans against a range-chunking reference model.
module tb_prm_edge_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [14:0] code_lo = '0;
  logic [14:0] code_hi = '0;

  int          mmode = 0;
  logic [31:0] seed = 32'h1234_5678;

  always #5 clk = ~clk;

  logic [14:0] cc0, cc2;
  logic        mk0, mk2;
  logic        ov0, ov2;
  logic [31:0] od0, od2;
  logic [14:0] ob0, ob2;
  logic [5:0]  on0, on2;
  logic        bz0, bz2, dn0, dn2;
  logic [15:0] bc0, bc2;
  logic        d1, d2;

  function automatic logic fmask(input logic [14:0] c, input int md,
                                 input logic [31:0] sd);
    logic [31:0] h;
    h = ({17'd0, c} * 32'h9E37_79B1) ^ sd;
    if (md == 0) return c[0];
    if (md == 1) return 1'b1;
    return h[13] ^ h[27];
  endfunction

  assign mk0 = fmask(cc0, mmode, seed);

  // Checker with two register stages in front of the latency-2 instance
  always @(posedge clk) begin
    d1 <= fmask(cc2, mmode, seed);
    d2 <= d1;
  end
  assign mk2 = d2;

  prm_edge_scan_seq #(.CODE_W(15), .WORD_W(32), .CHK_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .code_lo(code_lo), .code_hi(code_hi),
    .chk_code(cc0), .chk_mask(mk0),
    .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_base(ob0), .out_count(on0),
    .busy(bz0), .done(dn0), .blocked_cnt(bc0)
  );

  prm_edge_scan_seq #(.CODE_W(15), .WORD_W(32), .CHK_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .code_lo(code_lo), .code_hi(code_hi),
    .chk_code(cc2), .chk_mask(mk2),
    .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_base(ob2), .out_count(on2),
    .busy(bz2), .done(dn2), .blocked_cnt(bc2)
  );

  typedef struct {
    logic [31:0] d;
    logic [14:0] b;
    logic [5:0]  n;
  } word_t;

  word_t       q0[$];
  word_t       q1[$];
  int          total = 0;
  int          bad = 0;
  logic        pst[2];
  logic [31:0] pd[2];
  logic [14:0] pb[2];
  logic [5:0]  pn[2];
  int          done_n[2];
  int          done_cyc[2];
  int          last_hs[2];
  logic        busy_seen[2];
  int          k;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int i, input logic v, input logic [31:0] d,
                     input logic [14:0] b, input logic [5:0] n,
                     input logic bz, input logic dn);
    word_t w;
    if (pst[i]) begin
      chk($sformatf("stall_valid%0d", i), 64'(v), 64'd1);
      chk($sformatf("stall_data%0d", i), 64'(d), 64'(pd[i]));
      chk($sformatf("stall_base%0d", i), 64'(b), 64'(pb[i]));
      chk($sformatf("stall_cnt%0d", i), 64'(n), 64'(pn[i]));
    end
    pst[i] = v && !out_ready;
    pd[i] = d;
    pb[i] = b;
    pn[i] = n;
    if (v && out_ready) begin
      w.d = d;
      w.b = b;
      w.n = n;
      if (i == 0) q0.push_back(w);
      else q1.push_back(w);
      last_hs[i] = k;
    end
    if (bz) busy_seen[i] = 1'b1;
    if (dn) begin
      done_n[i]++;
      done_cyc[i] = k;
      chk($sformatf("done_busy%0d", i), 64'(bz), 64'd0);
    end
  endtask

  function automatic logic rdy(input int md, input int c);
    if (md == 1) return !(c >= 10 && c <= 60);
    if (md == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  task automatic cmp_inst(input int i, input int lo, input int hi,
                          input logic [15:0] bc);
    word_t q[$];
    int    idx;
    int    n;
    int    blk;
    logic [31:0] ed;
    if (i == 0) q = q0;
    else q = q1;
    idx = 0;
    blk = 0;
    for (int b = lo; b <= hi; b += 32) begin
      n = (hi - b + 1 < 32) ? hi - b + 1 : 32;
      ed = '0;
      for (int j = 0; j < n; j++) begin
        ed[j] = fmask(15'(b + j), mmode, seed);
        blk += int'(ed[j]);
      end
      if (idx < q.size()) begin
        chk($sformatf("data%0d_w%0d", i, idx), 64'(q[idx].d), 64'(ed));
        chk($sformatf("base%0d_w%0d", i, idx), 64'(q[idx].b), 64'(b));
        chk($sformatf("cnt%0d_w%0d", i, idx), 64'(q[idx].n), 64'(n));
      end
      idx++;
    end
    chk($sformatf("nwords%0d", i), 64'(q.size()), 64'(idx));
    chk($sformatf("blocked%0d", i), 64'(bc), 64'(blk));
    chk($sformatf("done_pulses%0d", i), 64'(done_n[i]), 64'd1);
    if (lo > hi) begin
      chk($sformatf("empty_done_lat%0d", i), 64'(done_cyc[i]), 64'd1);
      chk($sformatf("empty_busy%0d", i), 64'(busy_seen[i]), 64'd0);
    end else begin
      chk($sformatf("done_after_hs%0d", i),
          64'(done_cyc[i] > last_hs[i]), 64'd1);
      chk($sformatf("busy_seen%0d", i), 64'(busy_seen[i]), 64'd1);
    end
  endtask

  task automatic run_scan(input int lo, input int hi, input int rmode,
                          input bit dup);
    int bound;
    int stop_at;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      pst[i] = 1'b0;
      done_n[i] = 0;
      done_cyc[i] = -1;
      last_hs[i] = -1;
      busy_seen[i] = 1'b0;
    end
    bound = (hi >= lo ? hi - lo + 1 : 0) * 6 + 200;
    stop_at = bound;
    k = 0;
    @(negedge clk);
    code_lo = 15'(lo);
    code_hi = 15'(hi);
    start = 1'b1;
    out_ready = rdy(rmode, 0);
    #1;
    mon(0, ov0, od0, ob0, on0, bz0, dn0);
    mon(1, ov2, od2, ob2, on2, bz2, dn2);
    for (k = 1; k <= bound && k <= stop_at; k++) begin
      @(negedge clk);
      start = dup && (k == 5);
      if (dup && k == 5) begin
        code_lo = 15'(lo + 3);
        code_hi = 15'(hi - 7);
      end
      out_ready = rdy(rmode, k);
      #1;
      mon(0, ov0, od0, ob0, on0, bz0, dn0);
      mon(1, ov2, od2, ob2, on2, bz2, dn2);
      if (done_n[0] > 0 && done_n[1] > 0 && stop_at == bound) begin
        stop_at = k + 3;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    cmp_inst(0, lo, hi, bc0);
    cmp_inst(1, lo, hi, bc2);
    chk("idle_busy0", 64'(bz0), 64'd0);
    chk("idle_busy2", 64'(bz2), 64'd0);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_code0"}, 64'(cc0), 64'd0);
    chk({p, "_valid0"}, 64'(ov0), 64'd0);
    chk({p, "_data0"}, 64'(od0), 64'd0);
    chk({p, "_base0"}, 64'(ob0), 64'd0);
    chk({p, "_cnt0"}, 64'(on0), 64'd0);
    chk({p, "_busy0"}, 64'(bz0), 64'd0);
    chk({p, "_done0"}, 64'(dn0), 64'd0);
    chk({p, "_blk0"}, 64'(bc0), 64'd0);
    chk({p, "_code2"}, 64'(cc2), 64'd0);
    chk({p, "_valid2"}, 64'(ov2), 64'd0);
    chk({p, "_data2"}, 64'(od2), 64'd0);
    chk({p, "_busy2"}, 64'(bz2), 64'd0);
    chk({p, "_blk2"}, 64'(bc2), 64'd0);
  endtask

  initial begin
    int lo;
    int len;
    int hi;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // T1: parity mask over one full word
    mmode = 0;
    run_scan(0, 31, 0, 1'b0);
    // T2: single code, mask always 1
    mmode = 1;
    run_scan(5, 5, 0, 1'b0);
    // T3: empty range
    run_scan(9, 3, 0, 1'b0);
    // T4: multi-word with output stall window and a start while busy
    mmode = 2;
    seed = 32'hC0DE_0004;
    run_scan(0, 99, 1, 1'b1);
    // T5: top of the code space
    mmode = 0;
    run_scan(15'h7FE0, 15'h7FFF, 0, 1'b0);

    // T6: reset in the middle of a scan
    mmode = 1;
    @(negedge clk);
    code_lo = 15'd0;
    code_hi = 15'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_reset_vals("abort");
    run_scan(0, 7, 0, 1'b0);

    // Randomized ranges, masks and back-pressure
    for (int r = 0; r < 6; r++) begin
      mmode = 2;
      seed = $urandom;
      lo = int'($urandom_range(0, 32767));
      len = int'($urandom_range(1, 150));
      hi = (lo + len - 1 > 32767) ? 32767 : lo + len - 1;
      run_scan(lo, hi, 2, (hi - lo) >= 40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
